// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      LD_DATA,
      RMW_RD,
      RMW_MERGE,
      ST_WR,
      ERR
   } lsu_state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

   // Half needs addr[0]==0, word needs addr[1:0]==0; byte is always aligned.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (funct3[1])
         mis = (addr_lo != 2'b00);
      else if (funct3[0])
         mis = addr_lo[0];
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rd_data,
   input  logic [2:0]       funct3,
   input  logic [1:0]       addr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] merge_data
);

   logic [4:0]       byte_sh;
   logic [4:0]       half_sh;
   logic [7:0]       lane_b;
   logic [15:0]      lane_h;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] ins;

   always_comb begin
      byte_sh = {addr_lo, 3'b000};
      half_sh = {addr_lo[1], 4'b0000};
      lane_b  = 8'(rd_data >> byte_sh);
      lane_h  = 16'(rd_data >> half_sh);

      case (funct3)
         LB:      load_data = {{(WIDTH-8){lane_b[7]}}, lane_b};
         LH:      load_data = {{(WIDTH-16){lane_h[15]}}, lane_h};
         LBU:     load_data = {{(WIDTH-8){1'b0}}, lane_b};
         LHU:     load_data = {{(WIDTH-16){1'b0}}, lane_h};
         default: load_data = rd_data;
      endcase

      case (funct3[1:0])
         2'b00: begin
            mask = {{(WIDTH-8){1'b0}}, 8'hFF} << byte_sh;
            ins  = {{(WIDTH-8){1'b0}}, wdata[7:0]} << byte_sh;
         end
         2'b01: begin
            mask = {{(WIDTH-16){1'b0}}, 16'hFFFF} << half_sh;
            ins  = {{(WIDTH-16){1'b0}}, wdata[15:0]} << half_sh;
         end
         default: begin
            mask = '1;
            ins  = wdata;
         end
      endcase
      merge_data = (rd_data & ~mask) | ins;
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding request, read-modify-write for sub-word stores.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
//
// state     | meaning
// IDLE      | ready for a request
// LD_REQ    | memory read issued for a load
// LD_DATA   | read data back, extract lane into response
// RMW_RD    | memory read issued for a sub-word store
// RMW_MERGE | read data back, merge store lane into word
// ST_WR     | memory write issued, response follows
// ERR       | misaligned access, error response follows
module lsu
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   input  logic [4:0]       req_rd_sel,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_data,
   output logic [4:0]       rsp_rd_sel,
   output logic             rsp_err,
   output logic             mem_wr_en,
   output logic [2:0]       mem_wr_size,
   output logic [WIDTH-1:0] mem_wr_addr,
   output logic [WIDTH-1:0] mem_wr_data,
   output logic             mem_rd_en,
   output logic [2:0]       mem_rd_size,
   output logic [WIDTH-1:0] mem_rd_addr,
   output logic [4:0]       mem_rd_sel,
   input  logic [WIDTH-1:0] mem_rd_data
);

   lsu_state_e       state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [2:0]       funct3_q, funct3_d;
   logic             we_q, we_d;
   logic [4:0]       rd_sel_q, rd_sel_d;
   logic [WIDTH-1:0] merge_q, merge_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [4:0]       rsp_rd_sel_q, rsp_rd_sel_d;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] merge_data;
`ifdef LSU_MISALIGN_TRAP_EN
   logic             rsp_err_q, rsp_err_d;
`endif

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .rd_data    (mem_rd_data),
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         funct3_q     <= '0;
         we_q         <= 1'b0;
         rd_sel_q     <= '0;
         merge_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_rd_sel_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         funct3_q     <= funct3_d;
         we_q         <= we_d;
         rd_sel_q     <= rd_sel_d;
         merge_q      <= merge_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_rd_sel_q <= rsp_rd_sel_d;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rsp_err_q <= 1'b0;
      else       rsp_err_q <= rsp_err_d;
   end
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      funct3_d     = funct3_q;
      we_d         = we_q;
      rd_sel_d     = rd_sel_q;
      merge_d      = merge_q;
      rsp_valid_d  = 1'b0;
      rsp_data_d   = '0;
      rsp_rd_sel_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_d    = 1'b0;
`endif
      req_ready    = (state_q == IDLE);

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               we_d     = req_we;
               rd_sel_d = req_rd_sel;
               if (!req_we)             state_d = LD_REQ;
               else if (req_funct3[1])  state_d = ST_WR;
               else                     state_d = RMW_RD;
`ifdef LSU_MISALIGN_TRAP_EN
               if (is_misaligned(req_funct3, req_addr[1:0])) state_d = ERR;
`endif
            end
         end
         LD_REQ:  state_d = LD_DATA;
         LD_DATA: begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = load_data;
            rsp_rd_sel_d = rd_sel_q;
            state_d      = IDLE;
         end
         RMW_RD:  state_d = RMW_MERGE;
         RMW_MERGE: begin
            merge_d = merge_data;
            state_d = ST_WR;
         end
         ST_WR: begin
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         ERR: begin
            rsp_valid_d = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_d   = 1'b1;
`endif
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_rd_en   = (state_q == LD_REQ) || (state_q == RMW_RD);
      mem_rd_size = MEM_SIZE_WORD;
      mem_rd_addr = addr_q >> 2;
      mem_rd_sel  = (state_q == LD_REQ) ? rd_sel_q : 5'd0;
      mem_wr_en   = (state_q == ST_WR);
      mem_wr_size = MEM_SIZE_WORD;
      mem_wr_addr = addr_q >> 2;
      // Word stores bypass the merge register entirely.
      mem_wr_data = funct3_q[1] ? wdata_q : merge_q;
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_rd_sel = rsp_rd_sel_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases then random traffic against a word-array model.
module tb_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd_sel;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd_sel;
   logic        rsp_err;
   logic        mem_wr_en;
   logic [2:0]  mem_wr_size;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        mem_rd_en;
   logic [2:0]  mem_rd_size;
   logic [31:0] mem_rd_addr;
   logic [4:0]  mem_rd_sel;
   logic [31:0] mem_rd_data = 32'd0;

   logic        pre_we = 1'b0;
   logic [5:0]  pre_addr = 6'd0;
   logic [31:0] pre_data = 32'd0;

   logic [31:0] tb_mem  [0:63];
   logic [31:0] ref_mem [0:63];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lsu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd_sel(req_rd_sel),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd_sel(rsp_rd_sel), .rsp_err(rsp_err),
      .mem_wr_en(mem_wr_en), .mem_wr_size(mem_wr_size), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en), .mem_rd_size(mem_rd_size),
      .mem_rd_addr(mem_rd_addr), .mem_rd_sel(mem_rd_sel), .mem_rd_data(mem_rd_data)
   );

   // Word-addressed memory with one-cycle read latency.
   always @(posedge clk) begin
      if (pre_we) tb_mem[pre_addr] <= pre_data;
      if (mem_wr_en) tb_mem[mem_wr_addr[5:0]] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= tb_mem[mem_rd_addr[5:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] bv, hv;
      bv = (w >> (8 * a[1:0])) & 32'hFF;
      hv = (w >> (16 * a[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (bv >= 32'd128)   ? bv + 32'hFFFFFF00 : bv;
         3'd1:    return (hv >= 32'd32768) ? hv + 32'hFFFF0000 : hv;
         3'd4:    return bv;
         3'd5:    return hv;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] r;
      r = w;
      for (int i = 0; i < 4; i++) begin
         if ((f3[1:0] == 2'b00 && i == int'(a[1:0])) ||
             (f3[1:0] == 2'b01 && (i / 2) == int'(a[1])) ||
             f3[1])
            r[8*i +: 8] = f3[1] ? wd[8*i +: 8] : wd[8*(i % ((f3[1:0] == 2'b01) ? 2 : 1)) +: 8];
      end
      return r;
   endfunction

   // Issues one request (called at a negedge) and checks its response; returns at the
   // negedge of the response cycle so the next call is back-to-back.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
      int          lat, nwr, nrd, wr_lat, widx, exp_lat;
      logic        got, mis;
      logic [31:0] wr_a, wr_d, rsel;
      widx = int'(addr[7:2]);
      mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1] && addr[1:0] != 2'b00);
`endif
      check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
      req_wdata = wd; req_rd_sel = rd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; got = 1'b0; nwr = 0; nrd = 0; wr_lat = 0; wr_a = '0; wr_d = '0; rsel = '0;
      while (!got && lat < 12) begin
         @(negedge clk);
         lat++;
         if (mem_wr_en) begin nwr++; wr_lat = lat; wr_a = mem_wr_addr; wr_d = mem_wr_data; end
         if (mem_rd_en) begin nrd++; rsel = {27'd0, mem_rd_sel}; end
         if (rsp_valid) got = 1'b1;
      end
      check("rsp_valid_seen", {31'd0, got}, 32'd1);
      if (mis) begin
         check("err_latency", 32'(lat), 32'd2);
         check("err_flag", {31'd0, rsp_err}, 32'd1);
         check("err_data", rsp_data, 32'd0);
         check("err_no_rd", 32'(nrd), 32'd0);
         check("err_no_wr", 32'(nwr), 32'd0);
      end else begin
         check("rsp_err_low", {31'd0, rsp_err}, 32'd0);
         if (!we) begin
            check("load_latency", 32'(lat), 32'd3);
            check("load_data", rsp_data, ref_load(ref_mem[widx], f3, addr));
            check("load_rd_sel", {27'd0, rsp_rd_sel}, {27'd0, rd});
            check("load_mem_rd_sel", rsel, {27'd0, rd});
            check("load_rd_count", 32'(nrd), 32'd1);
            check("load_wr_count", 32'(nwr), 32'd0);
         end else begin
            exp_lat = f3[1] ? 2 : 4;
            check("store_latency", 32'(lat), 32'(exp_lat));
            check("store_rsp_data", rsp_data, 32'd0);
            check("store_rsp_rd_sel", {27'd0, rsp_rd_sel}, 32'd0);
            check("store_rd_count", 32'(nrd), f3[1] ? 32'd0 : 32'd1);
            check("store_wr_count", 32'(nwr), 32'd1);
            check("store_wr_cycle", 32'(wr_lat), 32'(exp_lat - 1));
            check("store_wr_addr", wr_a, 32'(widx));
            ref_mem[widx] = ref_store(ref_mem[widx], f3, addr, wd);
            check("store_wr_data", wr_d, ref_mem[widx]);
         end
      end
   endtask

   initial begin
      int nwr;
      logic [31:0] v;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = '0; req_wdata = '0; req_rd_sel = '0;

      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         v = (i == 4) ? 32'h8899AABB : $urandom;
         pre_we = 1'b1; pre_addr = 6'(i); pre_data = v; ref_mem[i] = v;
      end
      @(negedge clk);
      pre_we = 1'b0;

      check("reset_req_ready", {31'd0, req_ready}, 32'd1);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      check("reset_rsp_rd_sel", {27'd0, rsp_rd_sel}, 32'd0);
      check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("reset_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("reset_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
      check("mem_size_code", {29'd0, mem_rd_size}, 32'd2);
      reset = 1'b0;
      @(negedge clk);

      do_req(1'b0, 3'b000, 32'h12, 32'h0, 5'd7);
      check("lb_0x12_value", rsp_data, 32'hFFFFFF99);
      do_req(1'b0, 3'b101, 32'h10, 32'h0, 5'd3);
      check("lhu_0x10_value", rsp_data, 32'h0000AABB);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd9);
      check("lw_0x10_value", rsp_data, 32'h8899AABB);
      do_req(1'b1, 3'b000, 32'h11, 32'h55, 5'd4);
      check("sb_0x11_mem_word", tb_mem[4], 32'h889955BB);
      check("wr_size_code", {29'd0, mem_wr_size}, 32'd2);
      do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 5'd0);
      do_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd12);
      check("lw_after_sw_value", rsp_data, 32'hDEADBEEF);
      do_req(1'b0, 3'b010, 32'h13, 32'h0, 5'd5);
`ifndef LSU_MISALIGN_TRAP_EN
      check("lw_0x13_word4", rsp_data, 32'h889955BB);
`endif

      // Reset while the sub-word store sits in RMW_MERGE.
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h18;
      req_wdata = 32'h1234; req_rd_sel = 5'd0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      nwr = 0;
      repeat (2) begin @(negedge clk); if (mem_wr_en) nwr++; end
      reset = 1'b1;
      #1 check("async_reset_ready", {31'd0, req_ready}, 32'd1);
      check("async_reset_no_wr", {31'd0, mem_wr_en}, 32'd0);
      @(negedge clk); if (mem_wr_en) nwr++;
      reset = 1'b0;
      repeat (3) begin @(negedge clk); if (mem_wr_en) nwr++; end
      check("rmw_abort_no_wr", 32'(nwr), 32'd0);
      check("rmw_abort_ready", {31'd0, req_ready}, 32'd1);
      check("rmw_abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("rmw_abort_mem_word", tb_mem[6], ref_mem[6]);

      for (int k = 0; k < 60; k++) begin
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                $urandom, 5'($urandom_range(0, 31)));
      end

      @(negedge clk);
      check("rsp_valid_single_cycle", {31'd0, rsp_valid}, 32'd0);
      for (int i = 0; i < 64; i++) check("final_mem", tb_mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and byte-address width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1 (1=store), req_funct3 in 3 (RISC-V load/store funct3), req_addr in WIDTH (byte address), req_wdata in WIDTH, req_rd_sel in 5 (destination register).
REQ-005 SHALL have ports rsp_valid out 1, rsp_data out WIDTH, rsp_rd_sel out 5, rsp_err out 1.
REQ-006 SHALL have ports mem_wr_en out 1, mem_wr_size out 3, mem_wr_addr out WIDTH, mem_wr_data out WIDTH, mem_rd_en out 1, mem_rd_size out 3, mem_rd_addr out WIDTH, mem_rd_sel out 5, mem_rd_data in WIDTH. This is the initiator side of the word-addressed data memory, which returns mem_rd_data one cycle after mem_rd_en.

Function
REQ-007 SHALL accept a request on a posedge with req_valid && req_ready; the block SHALL latch addr, wdata, funct3, we and rd_sel into hold registers.
REQ-008 SHALL assert req_ready only in state IDLE.
REQ-009 SHALL use states IDLE, LD_REQ, LD_DATA, RMW_RD, RMW_MERGE, ST_WR, ERR.
REQ-010 Transitions out of IDLE on accept SHALL be: load -> LD_REQ; word store -> ST_WR; byte/half store -> RMW_RD.
REQ-011 Fixed transitions SHALL be LD_REQ->LD_DATA->IDLE, RMW_RD->RMW_MERGE->ST_WR->IDLE, and ERR->IDLE.
REQ-012 mem_* outputs SHALL be combinational from state and hold registers; mem_*_addr = addr>>2; mem_*_size = 3'b010; all enables 0 outside LD_REQ/RMW_RD (mem_rd_en) and ST_WR (mem_wr_en).
REQ-013 mem_rd_sel SHALL equal held rd_sel in LD_REQ and 0 otherwise.
REQ-014 Lanes SHALL be little-endian: byte lane addr[1:0], lane 0 = bits[7:0]; half lane addr[1], half 0 = bits[15:0].
REQ-015 In LD_DATA the block SHALL extract the lane from mem_rd_data: funct3 000/001 sign-extend, 100/101 zero-extend, 010/011/110/111 full word. The result SHALL be registered into rsp_data.
REQ-016 In RMW_MERGE the block SHALL register mem_rd_data with only the addressed byte/half lane replaced by req_wdata[7:0]/[15:0]. ST_WR SHALL write the merged word, or the raw wdata for word stores.
REQ-017 Store width SHALL use funct3[1:0] only: 00 byte, 01 half, 1x word.
REQ-018 rsp_valid SHALL be a registered one-cycle pulse on leaving LD_DATA, ST_WR or ERR.
REQ-019 Latency SHALL be as follows, where N is the accept cycle: load rsp_valid in N+3; word store in N+2; sub-word store in N+4.
REQ-020 On every store response, rsp_data SHALL be 0 and rsp_rd_sel SHALL be 0. On load responses, rsp_rd_sel SHALL equal the held rd_sel.
REQ-021 A new request SHALL be acceptable in the same cycle rsp_valid is high (back-to-back, no bubble beyond the above).

Reset
REQ-022 reset SHALL force state IDLE and set rsp_valid=0, rsp_data=0, rsp_rd_sel=0, rsp_err=0 and all hold registers to 0, immediately and asynchronously.
REQ-023 Reset in any state, including RMW_RD/RMW_MERGE, SHALL produce no mem_wr_en pulse; a partial read-modify-write is abandoned.

Configuration
REQ-024 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->ERR with no memory access. That request SHALL get rsp_valid=1 and rsp_err=1 in N+2, with rsp_data=0.
REQ-025 Without LSU_MISALIGN_TRAP_EN, rsp_err SHALL be tied 0. Halves SHALL ignore addr[0], words SHALL ignore addr[1:0], and state ERR SHALL be unreachable.

Structure
REQ-026 Package lsu_pkg SHALL hold the state enum, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the size code 3'b010.
REQ-027 Lane extraction/extension and store merge SHALL live in combinational sub-module lsu_align.

Verification
REQ-028 Memory word 4 = 0x8899AABB; LB addr 0x12 -> rsp_data 0xFFFFFF99 in N+3, and rsp_rd_sel equals the issued rd_sel.
REQ-029 Same word; LHU addr 0x10 -> 0x0000AABB; LW addr 0x10 -> 0x8899AABB.
REQ-030 SB addr 0x11 wdata 0x55 -> exactly one mem_wr_en in N+3, addr 4, data 0x889955BB; rsp_valid in N+4.
REQ-031 SW addr 0x20 wdata 0xDEADBEEF -> mem_wr_en in N+1, addr 8; rsp_valid in N+2; a following LW is accepted in the rsp_valid cycle and returns 0xDEADBEEF.
REQ-032 Assert reset in RMW_MERGE -> no mem_wr_en, req_ready=1 after release, memory unchanged.
REQ-033 With the macro defined, LW addr 0x13 -> rsp_err=1 in N+2 and no mem enables. Without the macro, the same request returns word 4 with rsp_err=0.
